// File: rtl/stack_ctrl.sv
// Stack sequencer owning a single-port scratch RAM (registered read, 1-cycle latency).
// Optional high-water-mark tracking is enabled with `define STACK_CTRL_HWM_EN.
module stack_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_wen,
  input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef STACK_CTRL_HWM_EN
  ,
  output logic [ADDR_WIDTH:0]   hwm,
  input  logic                  hwm_clr
`endif
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_POKE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_WAIT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   sp_q, sp_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  ram_wen_q, ram_wen_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [ADDR_WIDTH:0]   sp_inc;
  logic [ADDR_WIDTH:0]   sp_dec;
  logic                  cmd_err;

  // sp never exceeds capacity, so its MSB alone marks the full condition
  assign full      = sp_q[ADDR_WIDTH];
  assign empty     = (sp_q == '0);
  assign depth     = sp_q;
  assign sp_inc    = sp_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign sp_dec    = sp_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign cmd_ready = (state_q == IDLE) && !RST;
  assign cmd_err   = (cmd_op == OP_PUSH) ? full : empty;

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wen   = ram_wen_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wen_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_err) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            unique case (cmd_op)
              OP_PUSH: begin
                sp_d        = sp_inc;
                ram_addr_d  = sp_q[ADDR_WIDTH-1:0];
                ram_wdata_d = cmd_wdata;
                ram_wen_d   = 1'b1;
                state_d     = WR;
              end
              OP_POKE: begin
                ram_addr_d  = sp_dec[ADDR_WIDTH-1:0];
                ram_wdata_d = cmd_wdata;
                ram_wen_d   = 1'b1;
                state_d     = WR;
              end
              OP_POP: begin
                sp_d       = sp_dec;
                ram_addr_d = sp_dec[ADDR_WIDTH-1:0];
                state_d    = RD_ADDR;
              end
              default: begin
                ram_addr_d = sp_dec[ADDR_WIDTH-1:0];
                state_d    = RD_ADDR;
              end
            endcase
          end
        end
      end
      WR: begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ram_wdata_q;
      end
      RD_ADDR: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ram_rdata;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      sp_q        <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wen_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wen_q   <= ram_wen_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef STACK_CTRL_HWM_EN
  logic [ADDR_WIDTH:0] hwm_q, hwm_d;

  // A clear lands on the post-edge depth, even if a push happens in the same cycle
  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr) begin
      hwm_d = sp_d;
    end else if (sp_d > hwm_q) begin
      hwm_d = sp_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl with a behavioural 256x32 registered-read RAM.
// Builds with or without STACK_CTRL_HWM_EN.
module tb_stack_ctrl;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_POKE = 2'b11;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [8:0]  depth;
  logic        full;
  logic        empty;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wen;
  logic [31:0] ram_rdata;
`ifdef STACK_CTRL_HWM_EN
  logic [8:0]  hwm;
  logic        hwm_clr;
`endif

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;
  int wen_count = 0;
  int rsp_count = 0;
  int accept_count = 0;
  logic [31:0] rsp_log [$];

  logic [7:0]  last_addr;
  int          lat;
  logic        got_err;
  logic [31:0] got_data;

  stack_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .CLK(clk),
    .RST(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .depth(depth),
    .full(full),
    .empty(empty),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_wen(ram_wen),
    .ram_rdata(ram_rdata)
`ifdef STACK_CTRL_HWM_EN
    ,
    .hwm(hwm),
    .hwm_clr(hwm_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: read-first, registered data out
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (ram_wen === 1'b1) wen_count++;
    if (rsp_valid === 1'b1) begin
      rsp_count++;
      rsp_log.push_back(rsp_rdata);
    end
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) accept_count++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command, wait for its response, return latency from the accept edge
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] wdata,
                               output int latency, output logic err, output logic [31:0] data);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_wdata = wdata;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    last_addr = ram_addr;
    latency = 1;
    while (!rsp_valid && latency < 10) begin
      @(posedge clk);
      #1;
      latency++;
    end
    err  = rsp_err;
    data = rsp_rdata;
    checkOutput("ready_in_done", {63'd0, cmd_ready}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rsp_single_pulse", {63'd0, rsp_valid}, 64'd0);
  endtask

  initial begin
    int gap;
    int base_rsp;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = OP_PUSH;
    cmd_wdata = '0;
`ifdef STACK_CTRL_HWM_EN
    hwm_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", {63'd0, cmd_ready}, 64'd0);
    checkOutput("rst_depth", {55'd0, depth}, 64'd0);
    checkOutput("rst_empty", {63'd0, empty}, 64'd1);
    checkOutput("rst_full", {63'd0, full}, 64'd0);
    checkOutput("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("rst_ram_wen", {63'd0, ram_wen}, 64'd0);
    checkOutput("rst_ram_addr", {56'd0, ram_addr}, 64'd0);
    checkOutput("rst_ram_wdata", {32'd0, ram_wdata}, 64'd0);
    checkOutput("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

    // 1: single push then pop
    wen_count = 0;
    applyStimulus(OP_PUSH, 32'h1111_1111, lat, got_err, got_data);
    checkOutput("t1_push_lat", lat, 2);
    checkOutput("t1_push_err", {63'd0, got_err}, 64'd0);
    checkOutput("t1_push_data", {32'd0, got_data}, 64'h1111_1111);
    checkOutput("t1_depth1", {55'd0, depth}, 64'd1);
    checkOutput("t1_wen_cycles", wen_count, 1);
    applyStimulus(OP_POP, 32'h0, lat, got_err, got_data);
    checkOutput("t1_pop_lat", lat, 3);
    checkOutput("t1_pop_err", {63'd0, got_err}, 64'd0);
    checkOutput("t1_pop_data", {32'd0, got_data}, 64'h1111_1111);
    checkOutput("t1_depth0", {55'd0, depth}, 64'd0);
    checkOutput("t1_empty", {63'd0, empty}, 64'd1);

    // 2: underflow
    wen_count = 0;
    applyStimulus(OP_POP, 32'h0, lat, got_err, got_data);
    checkOutput("t2_lat", lat, 1);
    checkOutput("t2_err", {63'd0, got_err}, 64'd1);
    checkOutput("t2_data", {32'd0, got_data}, 64'd0);
    checkOutput("t2_wen", wen_count, 0);
    checkOutput("t2_depth", {55'd0, depth}, 64'd0);

    // 3: fill to capacity, overflow, drain in LIFO order
    for (int i = 0; i < 256; i++) begin
      applyStimulus(OP_PUSH, i, lat, got_err, got_data);
      if (i == 0 || i == 255) checkOutput("t3_push_lat", lat, 2);
    end
    checkOutput("t3_full", {63'd0, full}, 64'd1);
    checkOutput("t3_depth256", {55'd0, depth}, 64'd256);
    wen_count = 0;
    applyStimulus(OP_PUSH, 32'hDEAD_BEEF, lat, got_err, got_data);
    checkOutput("t3_ovf_err", {63'd0, got_err}, 64'd1);
    checkOutput("t3_ovf_lat", lat, 1);
    checkOutput("t3_ovf_wen", wen_count, 0);
    checkOutput("t3_ovf_depth", {55'd0, depth}, 64'd256);
`ifdef STACK_CTRL_HWM_EN
    checkOutput("t3_hwm", {55'd0, hwm}, 64'd256);
`endif
    for (int i = 255; i >= 0; i--) begin
      applyStimulus(OP_POP, 32'h0, lat, got_err, got_data);
      checkOutput("t3_pop_data", {32'd0, got_data}, i);
    end
    checkOutput("t3_drained", {55'd0, depth}, 64'd0);
    checkOutput("t3_not_full", {63'd0, full}, 64'd0);

    // 4: peek/poke on a single-entry stack
    applyStimulus(OP_PUSH, 32'hA5, lat, got_err, got_data);
    checkOutput("t4_push_addr", {56'd0, last_addr}, 64'd0);
    applyStimulus(OP_PEEK, 32'h0, lat, got_err, got_data);
    checkOutput("t4_peek1_data", {32'd0, got_data}, 64'hA5);
    checkOutput("t4_peek1_lat", lat, 3);
    checkOutput("t4_peek1_addr", {56'd0, last_addr}, 64'd0);
    checkOutput("t4_peek1_depth", {55'd0, depth}, 64'd1);
    applyStimulus(OP_POKE, 32'h5A, lat, got_err, got_data);
    checkOutput("t4_poke_lat", lat, 2);
    checkOutput("t4_poke_data", {32'd0, got_data}, 64'h5A);
    checkOutput("t4_poke_addr", {56'd0, last_addr}, 64'd0);
    checkOutput("t4_poke_depth", {55'd0, depth}, 64'd1);
    applyStimulus(OP_PEEK, 32'h0, lat, got_err, got_data);
    checkOutput("t4_peek2_data", {32'd0, got_data}, 64'h5A);
    checkOutput("t4_peek2_addr", {56'd0, last_addr}, 64'd0);
    checkOutput("t4_peek2_depth", {55'd0, depth}, 64'd1);
    applyStimulus(OP_POP, 32'h0, lat, got_err, got_data);
    checkOutput("t4_pop_data", {32'd0, got_data}, 64'h5A);

    // 5: cmd_valid held high, alternating push/pop
    rsp_log.delete();
    accept_count = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmd_op    = (i % 2 == 1) ? OP_POP : OP_PUSH;
      cmd_wdata = 32'h100 + i;
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!cmd_ready && gap < 10);
      checkOutput("t5_ready_gap", gap, (i % 2 == 1) ? 4 : 3);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_accepts", accept_count, 8);
    checkOutput("t5_rsp_count", rsp_log.size(), 8);
    for (int i = 0; i < rsp_log.size(); i++) begin
      checkOutput("t5_rsp_data", {32'd0, rsp_log[i]}, 32'h100 + (i - (i % 2)));
    end
    checkOutput("t5_depth", {55'd0, depth}, 64'd0);

    // 6: reset during the RD_WAIT cycle of a pop
    for (int i = 0; i < 3; i++) applyStimulus(OP_PUSH, 32'h200 + i, lat, got_err, got_data);
    checkOutput("t6_depth3", {55'd0, depth}, 64'd3);
    base_rsp = rsp_count;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = OP_POP;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_depth_rst", {55'd0, depth}, 64'd0);
    checkOutput("t6_rsp_valid_rst", {63'd0, rsp_valid}, 64'd0);
    checkOutput("t6_ready_rst", {63'd0, cmd_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t6_no_rsp", rsp_count, base_rsp);
    checkOutput("t6_idle_ready", {63'd0, cmd_ready}, 64'd1);
`ifdef STACK_CTRL_HWM_EN
    checkOutput("t6_hwm_rst", {55'd0, hwm}, 64'd0);
`endif
    for (int i = 0; i < 3; i++) applyStimulus(OP_PUSH, 32'h300 + i, lat, got_err, got_data);
    checkOutput("t6_repush_depth", {55'd0, depth}, 64'd3);
`ifdef STACK_CTRL_HWM_EN
    checkOutput("t6_hwm3", {55'd0, hwm}, 64'd3);
    applyStimulus(OP_POP, 32'h0, lat, got_err, got_data);
    checkOutput("t6_hwm_hold", {55'd0, hwm}, 64'd3);
    @(negedge clk);
    hwm_clr = 1'b1;
    @(posedge clk);
    #1;
    hwm_clr = 1'b0;
    checkOutput("t6_hwm_clr", {55'd0, hwm}, 64'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Sequencer and owner of the scratch-stack RAM port: a 256x32 single-port block with registered read data, one cycle read latency. It accepts one stack command at a time (PUSH/POP/PEEK/POKE) from the CPU core via a valid/ready handshake. It then drives the RAM address, write data and write enable, and returns a one-cycle response pulse. It owns the stack pointer and full/empty detection, so the core no longer hand-sequences fixed RAM wait phases.

Parameters:
ADDR_WIDTH, 8, RAM address width; capacity = 2**ADDR_WIDTH cells
DATA_WIDTH, 32, stack cell width

Ports:
CLK  in  1  system clock (16 MHz); all logic on posedge
RST  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE with RST low
cmd_op  in  2  00 PUSH, 01 POP, 10 PEEK, 11 POKE (overwrite top)
cmd_wdata  in  DATA_WIDTH  data for PUSH/POKE
rsp_valid  out  1  one-cycle completion pulse; no backpressure
rsp_err  out  1  qualified by rsp_valid: overflow/underflow, no RAM access done
rsp_rdata  out  DATA_WIDTH  read/written data, qualified by rsp_valid
depth  out  ADDR_WIDTH+1  current cell count (= sp)
full  out  1  depth == 2**ADDR_WIDTH (combinational from sp)
empty  out  1  depth == 0 (combinational from sp)
ram_addr  out  ADDR_WIDTH  to RAM addr (registered)
ram_wdata  out  DATA_WIDTH  to RAM din (registered)
ram_wen  out  1  to RAM write_en (registered)
ram_rdata  in  DATA_WIDTH  from RAM dout (registered inside RAM)

Behaviour:
- Clocking and reset: one clock domain, CLK. Reset is synchronous and active-high on RST.
- Reset values: state=IDLE, sp=0, ram_wen=0, ram_addr=0, ram_wdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0. cmd_ready=0 while RST high.
- States: IDLE, WR, RD_ADDR, RD_WAIT, DONE.
- Accept: on the edge where cmd_valid && cmd_ready (call it edge 0). Other inputs are ignored outside IDLE.
- PUSH, not full:
  - At accept: sp <= sp+1; ram_addr <= sp[ADDR_WIDTH-1:0]; ram_wdata <= cmd_wdata; ram_wen <= 1; state -> WR.
  - Cycle 1 (WR): ram_wen high for exactly this one cycle. State -> DONE, ram_wen <= 0.
  - Cycle 2: rsp_valid=1, rsp_err=0, rsp_rdata=pushed data.
- POKE, not empty: same as PUSH but ram_addr = sp-1 and sp is unchanged.
- POP, not empty:
  - At accept: sp <= sp-1; ram_addr <= sp-1; state -> RD_ADDR.
  - RD_ADDR: RAM samples the address at the edge that ends this cycle. State -> RD_WAIT.
  - RD_WAIT: ram_rdata is valid. Capture rsp_rdata <= ram_rdata at end of cycle. State -> DONE.
  - Cycle 3: rsp_valid=1.
- PEEK, not empty: same as POP, sp unchanged.
- Latency from accept to rsp_valid: writes 2 cycles, reads 3 cycles. Back-to-back: next accept possible in the cycle after DONE (the DONE cycle itself has cmd_ready=0).
- Error cases (no RAM access, ram_wen stays 0, sp unchanged):
  - PUSH when full, or POP/PEEK/POKE when empty.
  - At accept, state -> DONE. Cycle 1: rsp_valid=1, rsp_err=1, rsp_rdata=0.
- rsp_rdata holds its value between responses. rsp_valid and rsp_err are low outside DONE.
- sp range is 0..2**ADDR_WIDTH. It never wraps; full/empty guards make wrap impossible.
- RST mid-operation:
  - Next edge forces all reset values and drops any pending response.
  - A RAM write already in its WR cycle may land; that is harmless since sp=0.

Optional Feature:
Macro: STACK_CTRL_HWM_EN.
- Defined:
  - Adds output port hwm (ADDR_WIDTH+1 bits), the high-water mark: max depth reached since reset.
  - Updated at the same edge as sp: hwm <= max(hwm, new sp). Reset to 0.
  - Adds input hwm_clr (1 bit): clears hwm to the current depth on the next edge. hwm_clr has priority over an increment in the same cycle; the result is the new sp.
- Undefined: ports hwm and hwm_clr are absent, with no extra logic.

Test Plan:
1. Reset, PUSH 0x11111111 then POP -> PUSH: rsp_valid 2 cycles after accept, depth=1. POP: rsp_rdata=0x11111111, rsp_err=0, 3 cycles after accept, depth=0, empty=1.
2. POP on empty stack -> rsp_valid+rsp_err at cycle 1, rsp_rdata=0, ram_wen never asserted, depth stays 0.
3. 256 PUSHes of values 0..255, then a 257th PUSH -> full=1 after the 256th, 257th returns rsp_err=1 with depth=256. Then 256 POPs return 255 down to 0 in order.
4. PUSH 0xA5, PEEK, POKE 0x5A, PEEK -> PEEKs return 0xA5 then 0x5A, depth=1 throughout. ram_addr=0 for all RAM accesses.
5. cmd_valid held high continuously with alternating PUSH/POP -> one accept per command, cmd_ready low in every non-IDLE cycle, no dropped or duplicated commands.
6. RST asserted in RD_WAIT of a POP at depth 3 -> next cycle state IDLE, depth=0, rsp_valid never pulses. With STACK_CTRL_HWM_EN defined: hwm=0 after reset, and hwm=3 after re-pushing 3 values.
